// File: rtl/rs_age_ordered_if.sv
// Bundle between rs_age_ordered and its neighbours: decoder insert port,
// ALU issue port, CDB broadcast channels and the occupancy count.
// master = decoder/ALU/CDB side, slave = reservation station.
interface rs_age_ordered_if #(
    parameter int DEPTH_W = 3,
    parameter int ROB_W   = 4,
    parameter int TYPE_W  = 5,
    parameter int NUM_CDB = 2
);
    logic                     dec_rdy;
    logic                     dec_full;
    logic [TYPE_W-1:0]        dec_type;
    logic [31:0]              dec_data_j;
    logic [31:0]              dec_data_k;
    logic                     dec_pending_j;
    logic                     dec_pending_k;
    logic [ROB_W-1:0]         dec_dep_j;
    logic [ROB_W-1:0]         dec_dep_k;
    logic [ROB_W-1:0]         dec_rob_id;
    logic [31:0]              dec_imm;

    logic                     issue_valid;
    logic                     issue_ready;
    logic [TYPE_W-1:0]        issue_type;
    logic [ROB_W-1:0]         issue_rob_id;
    logic [31:0]              issue_data_j;
    logic [31:0]              issue_data_k;
    logic [31:0]              issue_imm;

    logic [NUM_CDB-1:0]       cdb_en;
    logic [NUM_CDB*ROB_W-1:0] cdb_rob_id;
    logic [NUM_CDB*32-1:0]    cdb_data;

    logic [DEPTH_W:0]         count;

    modport master (
        output dec_rdy, dec_type, dec_data_j, dec_data_k, dec_pending_j,
               dec_pending_k, dec_dep_j, dec_dep_k, dec_rob_id, dec_imm,
               issue_ready, cdb_en, cdb_rob_id, cdb_data,
        input  dec_full, issue_valid, issue_type, issue_rob_id,
               issue_data_j, issue_data_k, issue_imm, count
    );

    modport slave (
        input  dec_rdy, dec_type, dec_data_j, dec_data_k, dec_pending_j,
               dec_pending_k, dec_dep_j, dec_dep_k, dec_rob_id, dec_imm,
               issue_ready, cdb_en, cdb_rob_id, cdb_data,
        output dec_full, issue_valid, issue_type, issue_rob_id,
               issue_data_j, issue_data_k, issue_imm, count
    );
endinterface

// File: rtl/rs_age_ordered.sv
// Age-ordered single-ALU reservation station. Entries wake from NUM_CDB
// broadcast channels; the oldest ready entry (by age matrix, not by index
// or ROB tag) is offered to the ALU.
// Optional macro RS_WAKEUP_BYPASS_EN: a CDB match this cycle makes the
// entry ready immediately and forwards the broadcast data to issue_data_j/k.
module rs_age_ordered #(
    parameter int DEPTH   = 8,
    parameter int DEPTH_W = 3,
    parameter int ROB_W   = 4,
    parameter int TYPE_W  = 5,
    parameter int NUM_CDB = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                flush,
    rs_age_ordered_if.slave     bus
);
    logic [DEPTH-1:0]  present;
    logic [TYPE_W-1:0] ent_type   [DEPTH];
    logic [31:0]       ent_data_j [DEPTH];
    logic [31:0]       ent_data_k [DEPTH];
    logic [DEPTH-1:0]  pend_j;
    logic [DEPTH-1:0]  pend_k;
    logic [ROB_W-1:0]  dep_j      [DEPTH];
    logic [ROB_W-1:0]  dep_k      [DEPTH];
    logic [ROB_W-1:0]  ent_rob    [DEPTH];
    logic [31:0]       ent_imm    [DEPTH];
    logic [DEPTH-1:0]  older      [DEPTH];   // older[i][j]: j is older than i
    logic [DEPTH_W:0]  count_q;

    logic [DEPTH-1:0]   hit_j, hit_k;
    logic [31:0]        wdata_j [DEPTH];
    logic [31:0]        wdata_k [DEPTH];
    logic               ins_hit_j, ins_hit_k;
    logic [31:0]        ins_data_j, ins_data_k;
    logic [DEPTH-1:0]   ready;
    logic [DEPTH-1:0]   sel_oh;
    logic [DEPTH_W-1:0] sel_idx;
    logic [DEPTH_W-1:0] free_idx;
    logic               full;
    logic               any_ready;
    logic               do_ins, do_iss;

    // Lowest-numbered enabled channel whose tag matches wins.
    function automatic logic [32:0] cdb_match(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       en,
        input logic [NUM_CDB*ROB_W-1:0] ids,
        input logic [NUM_CDB*32-1:0]    data
    );
        logic [32:0] r;
        r = '0;
        for (int c = NUM_CDB - 1; c >= 0; c--) begin
            if (en[c] && ids[c*ROB_W +: ROB_W] == tag)
                r = {1'b1, data[c*32 +: 32]};
        end
        return r;
    endfunction

    // CDB tag match for every stored operand and for the incoming op.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            {hit_j[i], wdata_j[i]} = cdb_match(dep_j[i], bus.cdb_en, bus.cdb_rob_id, bus.cdb_data);
            {hit_k[i], wdata_k[i]} = cdb_match(dep_k[i], bus.cdb_en, bus.cdb_rob_id, bus.cdb_data);
        end
        {ins_hit_j, ins_data_j} = cdb_match(bus.dec_dep_j, bus.cdb_en, bus.cdb_rob_id, bus.cdb_data);
        {ins_hit_k, ins_data_k} = cdb_match(bus.dec_dep_k, bus.cdb_en, bus.cdb_rob_id, bus.cdb_data);
    end

    // Readiness, oldest-ready selection and lowest free slot.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_BYPASS_EN
            ready[i] = present[i] && (!pend_j[i] || hit_j[i]) && (!pend_k[i] || hit_k[i]);
`else
            ready[i] = present[i] && !pend_j[i] && !pend_k[i];
`endif
        end
        for (int i = 0; i < DEPTH; i++)
            sel_oh[i] = ready[i] && ((ready & older[i]) == '0);
        sel_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sel_oh[i]) sel_idx = DEPTH_W'(i);
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!present[i]) free_idx = DEPTH_W'(i);
    end

    assign any_ready = |ready;
    assign full      = (count_q == (DEPTH_W + 1)'(DEPTH));
    assign do_ins    = rdy_in && bus.dec_rdy && !full;
    assign do_iss    = rdy_in && any_ready && bus.issue_ready;

    assign bus.dec_full     = full;
    assign bus.count        = count_q;
    assign bus.issue_valid  = any_ready;
    assign bus.issue_type   = any_ready ? ent_type[sel_idx] : '0;
    assign bus.issue_rob_id = any_ready ? ent_rob[sel_idx]  : '0;
    assign bus.issue_imm    = any_ready ? ent_imm[sel_idx]  : '0;
`ifdef RS_WAKEUP_BYPASS_EN
    assign bus.issue_data_j = !any_ready ? '0 : (pend_j[sel_idx] ? wdata_j[sel_idx] : ent_data_j[sel_idx]);
    assign bus.issue_data_k = !any_ready ? '0 : (pend_k[sel_idx] ? wdata_k[sel_idx] : ent_data_k[sel_idx]);
`else
    assign bus.issue_data_j = any_ready ? ent_data_j[sel_idx] : '0;
    assign bus.issue_data_k = any_ready ? ent_data_k[sel_idx] : '0;
`endif

    // Entry state: flush/reset clear, otherwise wakeup, issue and insert.
    always_ff @(posedge clk_in) begin
        if (rst_in || (rdy_in && flush)) begin
            present <= '0;
            pend_j  <= '0;
            pend_k  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (present[i] && pend_j[i] && hit_j[i]) begin
                    ent_data_j[i] <= wdata_j[i];
                    pend_j[i]     <= 1'b0;
                end
                if (present[i] && pend_k[i] && hit_k[i]) begin
                    ent_data_k[i] <= wdata_k[i];
                    pend_k[i]     <= 1'b0;
                end
            end
            if (do_iss) present[sel_idx] <= 1'b0;
            if (do_ins) begin
                present[free_idx]    <= 1'b1;
                ent_type[free_idx]   <= bus.dec_type;
                ent_rob[free_idx]    <= bus.dec_rob_id;
                ent_imm[free_idx]    <= bus.dec_imm;
                dep_j[free_idx]      <= bus.dec_dep_j;
                dep_k[free_idx]      <= bus.dec_dep_k;
                pend_j[free_idx]     <= bus.dec_pending_j && !ins_hit_j;
                pend_k[free_idx]     <= bus.dec_pending_k && !ins_hit_k;
                ent_data_j[free_idx] <= (bus.dec_pending_j && ins_hit_j) ? ins_data_j : bus.dec_data_j;
                ent_data_k[free_idx] <= (bus.dec_pending_k && ins_hit_k) ? ins_data_k : bus.dec_data_k;
                older[free_idx]      <= present;
                for (int j = 0; j < DEPTH; j++) older[j][free_idx] <= 1'b0;
            end
            count_q <= count_q + (DEPTH_W + 1)'(do_ins) - (DEPTH_W + 1)'(do_iss);
        end
    end
endmodule

// File: tb/tb_rs_age_ordered.sv
// Directed bench for rs_age_ordered: reset, age ordering, reuse ordering,
// insert-time capture, full/backpressure, flush/freeze and wakeup latency.
module tb_rs_age_ordered;
    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic rdy_in = 1'b1;
    logic flush  = 1'b0;
    int total = 0;
    int bad   = 0;

    rs_age_ordered_if #(.DEPTH_W(3), .ROB_W(4), .TYPE_W(5), .NUM_CDB(2)) bus ();

    rs_age_ordered #(.DEPTH(8), .DEPTH_W(3), .ROB_W(4), .TYPE_W(5), .NUM_CDB(2)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs;
        bus.dec_rdy = 0; bus.dec_type = '0; bus.dec_data_j = '0; bus.dec_data_k = '0;
        bus.dec_pending_j = 0; bus.dec_pending_k = 0; bus.dec_dep_j = '0; bus.dec_dep_k = '0;
        bus.dec_rob_id = '0; bus.dec_imm = '0; bus.issue_ready = 0;
        bus.cdb_en = '0; bus.cdb_rob_id = '0; bus.cdb_data = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_in = 1; flush = 0; rdy_in = 1;
        tick();
        rst_in = 0;
    endtask

    // One decoder request; type = rob+1, imm = 0x1000+rob, data_k = ~data_j.
    task automatic insert(input logic [3:0] rob, input logic [31:0] dj, input logic pj,
                          input logic [3:0] depj, input logic iss);
        bus.dec_rob_id = rob; bus.dec_type = 5'(rob) + 5'd1; bus.dec_imm = 32'h1000 + 32'(rob);
        bus.dec_data_j = dj; bus.dec_data_k = ~dj; bus.dec_pending_j = pj; bus.dec_dep_j = depj;
        bus.dec_pending_k = 0; bus.dec_dep_k = '0;
        bus.dec_rdy = 1; bus.issue_ready = iss;
        tick();
        bus.dec_rdy = 0; bus.issue_ready = 0;
    endtask

    task automatic cdb0(input logic [3:0] tag, input logic [31:0] data);
        bus.cdb_en = 2'b01; bus.cdb_rob_id = {4'd0, tag}; bus.cdb_data = {32'd0, data};
    endtask

    task automatic test_reset;
        do_reset();
        insert(4'd2, 32'h5, 0, 4'd0, 0);
        do_reset();
        total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.issue_valid); end
        total++; if (bus.dec_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", bus.dec_full); end
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        total++; if (bus.issue_data_j !== 32'd0 || bus.issue_imm !== 32'd0 || bus.issue_rob_id !== 4'd0)
            begin bad++; $display("FAIL reset_data got=%h/%h/%h exp=0", bus.issue_data_j, bus.issue_imm, bus.issue_rob_id); end
    endtask

    task automatic test_age_order;
        do_reset();
        insert(4'd3, 32'h300, 0, 4'd0, 0);
        insert(4'd4, 32'h400, 0, 4'd0, 0);
        insert(4'd5, 32'h500, 0, 4'd0, 0);
        total++; if (bus.count !== 4'd3) begin bad++; $display("FAIL age_count3 got=%0d exp=3", bus.count); end
        tick(); tick();
        total++; if (bus.issue_rob_id !== 4'd3 || bus.issue_valid !== 1'b1) begin bad++; $display("FAIL age_hold got=%0d exp=3", bus.issue_rob_id); end
        total++; if (bus.issue_type !== 5'd4 || bus.issue_data_k !== ~32'h300) begin bad++; $display("FAIL age_fields got=%0d/%h exp=4/%h", bus.issue_type, bus.issue_data_k, ~32'h300); end
        bus.issue_ready = 1;
        tick();
        total++; if (bus.count !== 4'd2 || bus.issue_rob_id !== 4'd4) begin bad++; $display("FAIL age_second got=%0d/%0d exp=2/4", bus.count, bus.issue_rob_id); end
        total++; if (bus.issue_data_j !== 32'h400 || bus.issue_imm !== 32'h1004) begin bad++; $display("FAIL age_second_data got=%h/%h exp=400/1004", bus.issue_data_j, bus.issue_imm); end
        tick();
        total++; if (bus.count !== 4'd1 || bus.issue_rob_id !== 4'd5) begin bad++; $display("FAIL age_third got=%0d/%0d exp=1/5", bus.count, bus.issue_rob_id); end
        tick();
        total++; if (bus.count !== 4'd0 || bus.issue_valid !== 1'b0) begin bad++; $display("FAIL age_empty got=%0d/%0b exp=0/0", bus.count, bus.issue_valid); end
        bus.issue_ready = 0;
    endtask

    task automatic test_reuse;
        do_reset();
        for (int i = 0; i < 8; i++) insert(4'(8 + i), 32'hBAD, 1, 4'(i), 0);
        total++; if (bus.dec_full !== 1'b1 || bus.issue_valid !== 1'b0) begin bad++; $display("FAIL reuse_filled got=%0b/%0b exp=1/0", bus.dec_full, bus.issue_valid); end
        cdb0(4'd7, 32'h77); tick(); bus.cdb_en = '0;
        total++; if (bus.issue_rob_id !== 4'd15 || bus.issue_data_j !== 32'h77) begin bad++; $display("FAIL reuse_slot7 got=%0d/%h exp=15/77", bus.issue_rob_id, bus.issue_data_j); end
        bus.issue_ready = 1; tick(); bus.issue_ready = 0;
        total++; if (bus.count !== 4'd7 || bus.dec_full !== 1'b0) begin bad++; $display("FAIL reuse_freed got=%0d/%0b exp=7/0", bus.count, bus.dec_full); end
        insert(4'd1, 32'h4E, 0, 4'd0, 0);
        total++; if (bus.issue_rob_id !== 4'd1 || bus.count !== 4'd8) begin bad++; $display("FAIL reuse_new got=%0d/%0d exp=1/8", bus.issue_rob_id, bus.count); end
        cdb0(4'd2, 32'h22); tick(); bus.cdb_en = '0;
        total++; if (bus.issue_rob_id !== 4'd10 || bus.issue_data_j !== 32'h22) begin bad++; $display("FAIL reuse_slot2 got=%0d/%h exp=10/22", bus.issue_rob_id, bus.issue_data_j); end
        bus.issue_ready = 1; tick(); bus.issue_ready = 0;
        total++; if (bus.issue_rob_id !== 4'd1) begin bad++; $display("FAIL reuse_after2 got=%0d exp=1", bus.issue_rob_id); end
        cdb0(4'd0, 32'h100); tick(); bus.cdb_en = '0;
        total++; if (bus.issue_rob_id !== 4'd8 || bus.issue_data_j !== 32'h100) begin bad++; $display("FAIL reuse_slot0 got=%0d/%h exp=8/100", bus.issue_rob_id, bus.issue_data_j); end
        bus.issue_ready = 1; tick();
        total++; if (bus.issue_rob_id !== 4'd1 || bus.issue_data_j !== 32'h4E) begin bad++; $display("FAIL reuse_last got=%0d/%h exp=1/4e", bus.issue_rob_id, bus.issue_data_j); end
        tick(); bus.issue_ready = 0;
        total++; if (bus.issue_valid !== 1'b0 || bus.count !== 4'd5) begin bad++; $display("FAIL reuse_end got=%0b/%0d exp=0/5", bus.issue_valid, bus.count); end
    endtask

    task automatic test_capture;
        do_reset();
        bus.cdb_en = 2'b10; bus.cdb_rob_id = {4'd6, 4'd6}; bus.cdb_data = {32'hDEADBEEF, 32'h1111};
        insert(4'd2, 32'h0, 1, 4'd6, 0);
        bus.cdb_en = '0;
        total++; if (bus.issue_valid !== 1'b1 || bus.issue_data_j !== 32'hDEADBEEF) begin bad++; $display("FAIL capture_ins got=%0b/%h exp=1/deadbeef", bus.issue_valid, bus.issue_data_j); end
        bus.issue_ready = 1; tick(); bus.issue_ready = 0;
        insert(4'd3, 32'h0, 1, 4'd5, 0);
        bus.cdb_en = 2'b11; bus.cdb_rob_id = {4'd5, 4'd5}; bus.cdb_data = {32'h66, 32'h55};
        tick(); bus.cdb_en = '0;
        total++; if (bus.issue_rob_id !== 4'd3 || bus.issue_data_j !== 32'h55) begin bad++; $display("FAIL capture_lowest got=%0d/%h exp=3/55", bus.issue_rob_id, bus.issue_data_j); end
    endtask

    task automatic test_full;
        do_reset();
        for (int i = 0; i < 8; i++) insert(4'(i), 32'(i), 0, 4'd0, 0);
        total++; if (bus.dec_full !== 1'b1 || bus.count !== 4'd8) begin bad++; $display("FAIL full_set got=%0b/%0d exp=1/8", bus.dec_full, bus.count); end
        insert(4'd9, 32'h9, 0, 4'd0, 0);
        total++; if (bus.count !== 4'd8 || bus.issue_rob_id !== 4'd0) begin bad++; $display("FAIL full_drop got=%0d/%0d exp=8/0", bus.count, bus.issue_rob_id); end
        insert(4'd10, 32'hA, 0, 4'd0, 1);
        total++; if (bus.count !== 4'd7 || bus.dec_full !== 1'b0) begin bad++; $display("FAIL full_issue got=%0d/%0b exp=7/0", bus.count, bus.dec_full); end
        total++; if (bus.issue_rob_id !== 4'd1) begin bad++; $display("FAIL full_next got=%0d exp=1", bus.issue_rob_id); end
        insert(4'd11, 32'hB, 0, 4'd0, 1);
        total++; if (bus.count !== 4'd7 || bus.issue_rob_id !== 4'd2) begin bad++; $display("FAIL both_ops got=%0d/%0d exp=7/2", bus.count, bus.issue_rob_id); end
    endtask

    task automatic test_flush;
        do_reset();
        for (int i = 0; i < 5; i++) insert(4'(i + 2), 32'(i), 0, 4'd0, 0);
        bus.issue_ready = 1; flush = 1; rdy_in = 0;
        tick();
        total++; if (bus.count !== 4'd5 || bus.issue_rob_id !== 4'd2) begin bad++; $display("FAIL freeze got=%0d/%0d exp=5/2", bus.count, bus.issue_rob_id); end
        rdy_in = 1;
        tick();
        flush = 0; bus.issue_ready = 0;
        total++; if (bus.count !== 4'd0 || bus.issue_valid !== 1'b0) begin bad++; $display("FAIL flush got=%0d/%0b exp=0/0", bus.count, bus.issue_valid); end
        insert(4'd7, 32'h7, 0, 4'd0, 0);
        total++; if (bus.count !== 4'd1 || bus.issue_rob_id !== 4'd7) begin bad++; $display("FAIL post_flush got=%0d/%0d exp=1/7", bus.count, bus.issue_rob_id); end
    endtask

    task automatic test_bypass;
        do_reset();
        insert(4'd7, 32'h0, 1, 4'd3, 0);
        total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL byp_pending got=%0b exp=0", bus.issue_valid); end
        cdb0(4'd3, 32'h12);
        #1;
`ifdef RS_WAKEUP_BYPASS_EN
        total++; if (bus.issue_valid !== 1'b1 || bus.issue_data_j !== 32'h12) begin bad++; $display("FAIL byp_same got=%0b/%h exp=1/12", bus.issue_valid, bus.issue_data_j); end
        bus.issue_ready = 1; tick(); bus.issue_ready = 0; bus.cdb_en = '0;
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL byp_issued got=%0d exp=0", bus.count); end
`else
        total++; if (bus.issue_valid !== 1'b0) begin bad++; $display("FAIL byp_same got=%0b exp=0", bus.issue_valid); end
        tick(); bus.cdb_en = '0;
        total++; if (bus.issue_valid !== 1'b1 || bus.issue_data_j !== 32'h12) begin bad++; $display("FAIL byp_next got=%0b/%h exp=1/12", bus.issue_valid, bus.issue_data_j); end
        bus.issue_ready = 1; tick(); bus.issue_ready = 0;
        total++; if (bus.count !== 4'd0) begin bad++; $display("FAIL byp_issued got=%0d exp=0", bus.count); end
`endif
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_age_order();
        test_reuse();
        test_capture();
        test_full();
        test_flush();
        test_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/rs_age_ordered.md
Name: rs_age_ordered

Overview:
- Parametrised successor to the single-ALU reservation station.
- Holds decoded ALU ops, wakes operands from NUM_CDB common-data-bus channels, and issues the oldest ready entry (not lowest index) to one ALU.
- The ALU accepts through a valid/ready handshake.
- Sits between decoder/rename and the ALU; the ALU result path to the ROB is outside this block.

Parameters:
DEPTH, 8, number of entries (power of 2, >=2)
DEPTH_W, 3, log2(DEPTH)
ROB_W, 4, ROB tag width
TYPE_W, 5, op type width
NUM_CDB, 2, number of broadcast channels

Ports:
clk_in  in  1  clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; when low, no state changes
flush  in  1  mispredict flush (acts only when rdy_in=1)
dec_rdy  in  1  insert request
dec_full  out  1  no free entry
dec_type  in  TYPE_W  op type
dec_data_j / dec_data_k  in  32  operand values
dec_pending_j / dec_pending_k  in  1  operand awaits tag
dec_dep_j / dec_dep_k  in  ROB_W  producer tags
dec_rob_id  in  ROB_W  destination tag
dec_imm  in  32  immediate
issue_valid  out  1  an entry is ready to issue
issue_ready  in  1  ALU accepts this cycle
issue_type  out  TYPE_W  issued op type
issue_rob_id  out  ROB_W  issued tag
issue_data_j / issue_data_k  out  32  issued operands
issue_imm  out  32  issued immediate
cdb_en  in  NUM_CDB  per-channel valid
cdb_rob_id  in  NUM_CDB*ROB_W  packed tags, channel c at [c*ROB_W +: ROB_W]
cdb_data  in  NUM_CDB*32  packed data, channel c at [c*32 +: 32]
count  out  DEPTH_W+1  occupied entries

Behaviour:
- Reset: one clock, synchronous active-high (clk_in, rst_in). rst_in, or flush with rdy_in=1, clears all present bits, the age matrix and count. After reset: issue_valid=0, dec_full=0, count=0, all issue_* data outputs = 0.
- rdy_in=0: all state frozen. Outputs still reflect the current state.
- Per-entry state: present, type, data_j/k, pending_j/k, dep_j/k, rob_id, imm. The DEPTH x DEPTH age matrix older[i][j]=1 means entry j is older than entry i.
- Insert:
  - When dec_rdy & rdy_in & !dec_full, write to the lowest-index free slot e.
  - Set older[e][j]=present[j] for all j, and older[j][e]=0.
  - dec_rdy while dec_full: the request is dropped with no state change.
- Insert-time capture: if dec_pending_x and some cdb_en[c] has tag==dec_dep_x in the same cycle, store that channel's data and clear pending_x. The lowest-numbered matching channel wins.
- Wakeup: each cycle, every present entry with pending_x and a matching enabled CDB tag latches the data and clears pending_x. The lowest channel wins on multiple matches.
- Ready(i) = present & !pending_j & !pending_k.
- Selection:
  - issue index = the ready entry i with no ready j where older[i][j]=1.
  - issue_valid = any ready. issue_* are combinational from the selected entry.
- Issue handshake: on issue_valid & issue_ready & rdy_in, clear present of the selected entry. While issue_ready=0, the selection is held unless an older entry becomes ready.
- Same-cycle insert plus issue when full: the freed slot is not usable that cycle, so dec_full is registered-state based.
- count: +1 on insert, -1 on issue, unchanged when both occur.
- dec_full = (count==DEPTH).
- Flush wins over insert, issue and wakeup in the same cycle.
- Tag wrap: age is tracked by the matrix, never by comparing ROB tags.

Optional Feature:
- Macro RS_WAKEUP_BYPASS_EN.
- Defined:
  - An entry whose last pending operand(s) match a CDB this cycle counts as ready this cycle.
  - The CDB data is forwarded onto issue_data_j/k.
  - Latency from broadcast to issue is 0 cycles.
- Undefined: ready uses registered pending bits only, so the earliest issue is the cycle after the broadcast.

Test Plan:
1. Age order: insert A (rob 3), B (rob 4), C (rob 5), all operands ready, issue_ready=0 for 3 cycles, then 1 -> issues in order rob 3, 4, 5 on consecutive cycles, and count goes 3->2->1->0.
2. Oldest-first after reuse:
   - Fill DEPTH=8 entries with all pending; wake slot 7 then slot 2 via CDB0.
   - Issue slot 7's op, insert new op N into slot 7 ready, then wake slot 0.
   - Expected: slot 2 issues before slot 0, and slot 0 issues before N.
3. Insert capture: dec_pending_j=1, dec_dep_j=6 while cdb_en=2'b10 with ch1 tag 6, data 0xDEADBEEF -> entry ready; its issue_data_j=0xDEADBEEF.
4. Full/backpressure:
   - 8 inserts give dec_full=1.
   - A 9th dec_rdy is dropped (count stays 8).
   - An issue while dec_rdy=1 leaves count 7 and dec_full=0 next cycle.
5. Flush with rdy_in=1 mid-operation with 5 entries and a pending issue -> next cycle count=0, issue_valid=0. The same flush with rdy_in=0 has no effect.
6. Bypass: pending operand woken by CDB0 (data 0x12) at cycle t -> with RS_WAKEUP_BYPASS_EN, issue at t with data 0x12; without it, issue at t+1.
